// File: rtl/bram_pkg.sv
// Shared types and default widths for the BRAM request sequencer.
// Imported by the sequencer top, its command FIFO and the bench.
package bram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/bram_cmd_fifo.sv
// In-order command FIFO with wrap-bit pointers.
// Head entry is presented combinationally on rdata.
module bram_cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             one_left
);
  import bram_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
             && (wptr_q[AW] != rptr_q[AW]);
  assign empty    = (wptr_q == rptr_q);
  assign one_left = ((wptr_q - rptr_q) == (AW+1)'(1));
  assign rdata    = mem_q[rptr_q[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Payload storage needs no reset; pointers gate visibility.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bram_req_sequencer.sv
// Queues BRAM read/write commands and issues one per cycle,
// tracking read latency to produce single-cycle responses.
module bram_req_sequencer #(
  parameter int ADDR_W     = bram_pkg::DEF_ADDR_W,
  parameter int DATA_W     = bram_pkg::DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [15:0]       ops_count
);
  import bram_pkg::*;

  localparam int CW = 1 + ADDR_W + DATA_W;

  logic              push, pop;
  logic              full, empty, one_left;
  logic [CW-1:0]     head;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic [15:0]       ops_count_q, ops_count_d;

  assign cmd_ready = !reset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ISSUE) && !empty;
  assign {h_we, h_addr, h_wdata} = head;

  bram_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    ({cmd_we, cmd_addr, cmd_wdata}),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    rd_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    ops_count_d = ops_count_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   if (empty || (pop && one_left && !push))
                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      ops_count_d = ops_count_q + 16'd1;
      if (h_we) begin
        we_d      = 1'b1;
        wr_addr_d = h_addr;
        wr_data_d = h_wdata;
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = h_addr;
      end
    end
    infl_d    = '0;
    infl_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
    end
    rsp_d = rsp_q;
    if (infl_q[RD_LAT-1]) rsp_d = rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      infl_q      <= '0;
      rsp_q       <= '0;
      ops_count_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      infl_q      <= infl_d;
      rsp_q       <= rsp_d;
      ops_count_q <= ops_count_d;
    end
  end

  // Response data is live in the valid cycle, then held.
  assign rsp_valid = infl_q[RD_LAT-1];
  assign rsp_data  = rsp_valid ? rd_data : rsp_q;
  assign we        = we_q;
  assign rd_en     = rd_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign ops_count = ops_count_q;
  assign busy      = !empty || (state_q == ISSUE)
                  || rd_en_q || (|infl_q);

endmodule

// File: tb/tb_bram_req_sequencer.sv
// Scoreboard bench for bram_req_sequencer with a 1-cycle BRAM model.
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_bram_req_sequencer;
  import bram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        we, rd_en, rsp_valid, busy;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data, rsp_data;
  logic [15:0] ops_count;

  int total = 0;
  int bad = 0;

  cmd_t        exp_iss[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_mem [logic [7:0]];
  logic [31:0] mem [logic [7:0]];
  logic [31:0] rd_q = '0;
  logic        preload_req = 1'b0;
  int          max_run = 0;

  always #5 clk = ~clk;

  bram_req_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ops_count (ops_count)
  );

  function automatic logic [31:0] dflt(logic [7:0] a);
    return {24'hC0FFEE, a};
  endfunction

  // BRAM model: write commits at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (we) mem[wr_addr] = wr_data;
    if (rd_en) rd_q <= mem.exists(rd_addr) ? mem[rd_addr]
                                           : dflt(rd_addr);
  end
  assign rd_data = rd_q;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor
  logic        hist = 1'b0;
  logic [7:0]  exp_wa = '0, exp_ra = '0;
  logic [31:0] exp_rsp_hold = '0;
  logic [15:0] exp_ops = '0;
  int          run = 0;

  always @(negedge clk) begin
    cmd_t e;
    if (reset) begin
      hist = 1'b0;
      exp_wa = '0;
      exp_ra = '0;
      exp_rsp_hold = '0;
      exp_ops = '0;
      run = 0;
      exp_iss.delete();
      exp_rsp.delete();
    end else begin
      if (preload_req) exp_ops = 16'hFFFE;
      chk("we_rd_excl", 32'(we && rd_en), 32'd0);
      chk("push_full",
          32'(cmd_valid && cmd_ready && dut.u_fifo.full), 32'd0);
      if (we || rd_en) begin
        if (exp_iss.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: we=%b rd_en=%b", we, rd_en);
        end else begin
          e = exp_iss.pop_front();
          chk("issue_kind", 32'(we), 32'(e.we));
          if (we) begin
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", wr_data, e.wdata);
            exp_wa = e.addr;
          end else begin
            chk("rd_addr", 32'(rd_addr), 32'(e.addr));
            exp_ra = e.addr;
          end
          exp_ops = exp_ops + 16'd1;
          chk("ops_count", 32'(ops_count), 32'(exp_ops));
        end
      end
      if (!we) chk("wr_addr_hold", 32'(wr_addr), 32'(exp_wa));
      if (!rd_en) chk("rd_addr_hold", 32'(rd_addr), 32'(exp_ra));
      chk("rsp_timing", 32'(rsp_valid), 32'(hist));
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: data=%h", rsp_data);
        end else begin
          exp_rsp_hold = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, exp_rsp_hold);
        end
      end else begin
        chk("rsp_hold", rsp_data, exp_rsp_hold);
      end
      hist = rd_en;
      run = rd_en ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(logic w, logic [7:0] a, logic [31:0] d);
    cmd_t c;
    logic rdy;
    int   n;
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 50) begin
      rdy = cmd_ready;
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: addr=%h", a);
    end else begin
      c.we = w;
      c.addr = a;
      c.wdata = d;
      exp_iss.push_back(c);
      if (w) exp_mem[a] = d;
      else exp_rsp.push_back(exp_mem.exists(a) ? exp_mem[a] : dflt(a));
    end
  endtask

  task automatic idle(int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(string nm);
    chk({nm, "_iss_left"}, 32'(exp_iss.size()), 32'd0);
    chk({nm, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", 32'(ops_count), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    #1 chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // 8 back-to-back reads
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 32'd0);
    idle(8);
    chk("rd_run_len", 32'(max_run), 32'd8);
    chk("ops_after_8", 32'(ops_count), 32'd8);
    drained("b2b_rd");

    // write then read same address
    send(1'b1, 8'h10, 32'h0000_00A5);
    send(1'b0, 8'h10, 32'h0);
    idle(8);
    drained("wr_rd");

    // fill FIFO while issue is held off
    force dut.state_q = IDLE;
    for (int i = 0; i < 4; i++)
      send(1'b1, 8'h20 + 8'(i), 32'h1111_0000 + 32'(i));
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 8'h24;
    cmd_wdata = 32'h1111_0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold", 32'(cmd_ready), 32'd0);
    end
    release dut.state_q;
    send(1'b1, 8'h24, 32'h1111_0004);
    send(1'b0, 8'h22, 32'h0);
    idle(8);
    drained("full");

    // reset with 3 queued and a read going out
    force dut.state_q = IDLE;
    send(1'b0, 8'h10, 32'h0);
    send(1'b1, 8'h30, 32'h2222_0000);
    send(1'b1, 8'h31, 32'h2222_0001);
    send(1'b1, 8'h32, 32'h2222_0002);
    cmd_valid = 1'b0;
    release dut.state_q;
    n = 0;
    while (!rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rd_seen", 32'(rd_en), 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ops", 32'(ops_count), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1 chk("mid_post_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    idle(10);
    drained("mid_rst");

    // ops_count wrap
    force dut.ops_count_q = 16'hFFFE;
    preload_req = 1'b1;
    #1 release dut.ops_count_q;
    @(negedge clk);
    preload_req = 1'b0;
    chk("preload_ops", 32'(ops_count), 32'hFFFE);
    send(1'b1, 8'h40, 32'h3333_0000);
    send(1'b1, 8'h41, 32'h3333_0001);
    idle(8);
    chk("wrap_ops", 32'(ops_count), 32'd0);
    drained("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
